// File: rtl/reaction_game_core.sv
// Reaction game controller: latches a random target, counts a display number up at a
// mode-dependent rate, freezes it on select and scores the absolute error over a game.
module reaction_game_core #(
  parameter int unsigned NUM_W         = 14,
  parameter int unsigned MAX_NUM       = 9999,
  parameter int unsigned N_MODES       = 3,
  parameter int unsigned MODE_RESET    = 1,
  parameter int unsigned TICK_BASE     = 100000,
  parameter int unsigned TCNT_W        = 24,
  parameter int unsigned ROUNDS        = 3,
  parameter int unsigned LED_W         = 16,
  parameter int unsigned LED_STEP_LOG2 = 6,
  parameter int unsigned SCORE_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_sel,
  input  logic [NUM_W-1:0]   rand_val,
  output logic [2:0]         state,
  output logic [1:0]         mode,
  output logic [NUM_W-1:0]   number,
  output logic [LED_W-1:0]   led,
  output logic [3:0]         round,
  output logic [SCORE_W-1:0] total
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StTarget = 3'd1,
    StRun    = 3'd2,
    StResult = 3'd3,
    StDone   = 3'd4
  } state_e;

  localparam logic [1:0]         ModeMax    = 2'(N_MODES - 1);
  localparam logic [NUM_W-1:0]   MaxNum     = NUM_W'(MAX_NUM);
  localparam logic [TCNT_W-1:0]  TickBase   = TCNT_W'(TICK_BASE);
  localparam logic [3:0]         RoundLast  = 4'(ROUNDS - 1);
  localparam logic [SCORE_W-1:0] MaxNumS    = SCORE_W'(MAX_NUM);
  localparam logic [SCORE_W-1:0] GoodThresh = SCORE_W'(ROUNDS << LED_STEP_LOG2);

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [NUM_W-1:0]   number_q, number_d;
  logic [NUM_W-1:0]   target_q, target_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [3:0]         round_q, round_d;
  logic [SCORE_W-1:0] total_q, total_d;
  logic [TCNT_W-1:0]  tick_q, tick_d;
  logic               up_q, down_q, sel_q;

  logic               up_press, down_press, sel_press;
  logic [NUM_W-1:0]   rand_clamp, err, err_steps, total_clamp;
  logic [TCNT_W-1:0]  period_m1;
  logic [SCORE_W:0]   total_sum;
  logic [SCORE_W-1:0] total_sat;
  logic [LED_W-1:0]   led_bar;

  assign up_press   = btn_up & ~up_q;
  assign down_press = btn_down & ~down_q;
  assign sel_press  = btn_sel & ~sel_q;

  always_comb begin
    rand_clamp  = (rand_val > MaxNum) ? MaxNum : rand_val;
    period_m1   = (TickBase << (ModeMax - mode_q)) - TCNT_W'(1);
    err         = (number_q >= target_q) ? (number_q - target_q) : (target_q - number_q);
    err_steps   = err >> LED_STEP_LOG2;
    total_sum   = {1'b0, total_q} + (SCORE_W + 1)'(err);
    total_sat   = total_sum[SCORE_W] ? '1 : total_sum[SCORE_W-1:0];
    total_clamp = (total_q > MaxNumS) ? MaxNum : total_q[NUM_W-1:0];
    // Bit i is lit while i < LED_W - err_steps; fully dark once err_steps >= LED_W.
    for (int i = 0; i < int'(LED_W); i++) begin
      led_bar[i] = (i + int'(err_steps)) < int'(LED_W);
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    number_d = number_q;
    target_d = target_q;
    led_d    = led_q;
    round_d  = round_q;
    total_d  = total_q;
    tick_d   = tick_q;
    unique case (state_q)
      StIdle: begin
        if (up_press && !down_press && mode_q != ModeMax) begin
          mode_d = mode_q + 2'd1;
        end else if (down_press && !up_press && mode_q != 2'd0) begin
          mode_d = mode_q - 2'd1;
        end
        if (sel_press) begin
          state_d  = StTarget;
          target_d = rand_clamp;
          number_d = rand_clamp;
          led_d    = '0;
        end
      end
      StTarget: begin
        if (sel_press) begin
          state_d  = StRun;
          number_d = '0;
          tick_d   = '0;
        end
      end
      StRun: begin
        // A select press wins over a same-cycle increment so the shown value is scored.
        if (sel_press) begin
          state_d = StResult;
          led_d   = led_bar;
          total_d = total_sat;
        end else if (tick_q == period_m1) begin
          tick_d   = '0;
          number_d = (number_q == MaxNum) ? '0 : number_q + NUM_W'(1);
        end else begin
          tick_d = tick_q + TCNT_W'(1);
        end
      end
      StResult: begin
        if (sel_press) begin
          if (round_q == RoundLast) begin
            state_d  = StDone;
            number_d = total_clamp;
            led_d    = (total_q < GoodThresh) ? '1 : '0;
          end else begin
            state_d  = StTarget;
            round_d  = round_q + 4'd1;
            target_d = rand_clamp;
            number_d = rand_clamp;
            led_d    = '0;
          end
        end
      end
      StDone: begin
        if (sel_press) begin
          state_d  = StIdle;
          round_d  = '0;
          total_d  = '0;
          number_d = '0;
          led_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mode_q   <= 2'(MODE_RESET);
      number_q <= '0;
      target_q <= '0;
      led_q    <= '0;
      round_q  <= '0;
      total_q  <= '0;
      tick_q   <= '0;
      up_q     <= 1'b1;
      down_q   <= 1'b1;
      sel_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      number_q <= number_d;
      target_q <= target_d;
      led_q    <= led_d;
      round_q  <= round_d;
      total_q  <= total_d;
      tick_q   <= tick_d;
      up_q     <= btn_up;
      down_q   <= btn_down;
      sel_q    <= btn_sel;
    end
  end

  assign state  = state_q;
  assign mode   = mode_q;
  assign number = number_q;
  assign led    = led_q;
  assign round  = round_q;
  assign total  = total_q;

endmodule
